// File: rtl/mem_local_responder_if.sv
// Request/response bus between the memory arbiter and the local responder,
// and the single-port synchronous RAM port (one-cycle read latency).
interface mem_interface;
  logic        request;
  logic [31:2] addr;
  logic [4:0]  rlen;
  logic        rnw;
  logic        rmw;
  logic [3:0]  wbe;
  logic [31:0] wdata;
  logic [1:0]  id;
  logic        ack;
  logic        rvalid;
  logic [31:0] rdata;
  logic [1:0]  rid;
  logic        inv;
  logic [31:2] inv_addr;
  logic        write_outstanding;

  modport mem_slave (
    input  request, addr, rlen, rnw, rmw, wbe, wdata, id,
    output ack, rvalid, rdata, rid, inv, inv_addr, write_outstanding
  );

  modport mem_master (
    output request, addr, rlen, rnw, rmw, wbe, wdata, id,
    input  ack, rvalid, rdata, rid, inv, inv_addr, write_outstanding
  );
endinterface

interface local_memory_interface;
  logic [29:0] addr;
  logic        en;
  logic [3:0]  be;
  logic [31:0] data_in;
  logic [31:0] data_out;

  modport master (output addr, en, be, data_in, input data_out);
  modport slave  (input addr, en, be, data_in, output data_out);
endinterface

// File: rtl/mem_local_responder.sv
// Responder end of mem_interface backed by a local synchronous RAM: single-word
// writes, 1-32 word in-order burst reads. Optional write invalidate: MEM_LOCAL_INV_EN.
module mem_local_responder (
  input  logic                          clk,
  input  logic                          rst,
  mem_interface.mem_slave               mem,
  local_memory_interface.master         ram
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } state_e;

  state_e      state_q;
  logic [29:0] addr_q;
  logic [4:0]  cnt_q;
  logic [1:0]  id_q;
  logic [1:0]  rid_q;
  logic        rvalid_q;

  logic ack_s;
  logic rd_acc_s;
  logic wr_acc_s;
  logic burst_s;
  logic rd_issue_s;

  // Accept decode and RAM port steering; reset suppresses any RAM access.
  always_comb begin
    ack_s      = (state_q == ST_IDLE) & mem.request & rst;
    rd_acc_s   = ack_s & mem.rnw;
    wr_acc_s   = ack_s & ~mem.rnw;
    burst_s    = (state_q == ST_READ) & rst;
    rd_issue_s = rd_acc_s | burst_s;
    ram.en      = 1'b0;
    ram.addr    = 30'd0;
    ram.be      = 4'b0000;
    ram.data_in = 32'd0;
    if (ack_s) begin
      ram.en      = 1'b1;
      ram.addr    = mem.addr;
      ram.be      = mem.rnw ? 4'b0000 : mem.wbe;
      ram.data_in = mem.rnw ? 32'd0 : mem.wdata;
    end else if (burst_s) begin
      ram.en   = 1'b1;
      ram.addr = addr_q;
    end else begin
      ram.en = 1'b0;
    end
  end

  // Burst FSM: word 0 issues in the ack cycle, the remaining rlen words in READ.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= 30'd0;
      cnt_q    <= 5'd0;
      id_q     <= 2'd0;
      rid_q    <= 2'd0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_issue_s;
      case (state_q)
        ST_IDLE: begin
          if (rd_acc_s) begin
            addr_q  <= mem.addr + 30'd1;
            id_q    <= mem.id;
            rid_q   <= mem.id;
            cnt_q   <= mem.rlen;
            state_q <= (mem.rlen != 5'd0) ? ST_READ : ST_IDLE;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_READ: begin
          addr_q <= addr_q + 30'd1;
          rid_q  <= id_q;
          // cnt_q counts words still to issue; leaving at 1 keeps it from underflowing
          if (cnt_q <= 5'd1) begin
            cnt_q   <= 5'd0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q   <= cnt_q - 5'd1;
            state_q <= ST_READ;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= 5'd0;
        end
      endcase
    end
  end

  assign mem.ack               = ack_s;
  assign mem.rvalid            = rvalid_q;
  assign mem.rdata             = ram.data_out;
  assign mem.rid               = rid_q;
  assign mem.write_outstanding = 1'b0;

`ifdef MEM_LOCAL_INV_EN
  logic        inv_q;
  logic [29:0] inv_addr_q;

  // One-cycle invalidate pulse after each accepted write, for caches sharing the RAM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      inv_q      <= 1'b0;
      inv_addr_q <= 30'd0;
    end else begin
      inv_q <= wr_acc_s;
      if (wr_acc_s) begin
        inv_addr_q <= mem.addr;
      end else begin
        inv_addr_q <= inv_addr_q;
      end
    end
  end

  assign mem.inv      = inv_q;
  assign mem.inv_addr = inv_addr_q;
`else
  assign mem.inv      = 1'b0;
  assign mem.inv_addr = 30'd0;
`endif

endmodule

// File: tb/tb_mem_local_responder.sv
// Directed self-checking bench for mem_local_responder with a small behavioural RAM.
module tb_mem_local_responder;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_mis;

  mem_interface          mem_if ();
  local_memory_interface ram_if ();

  mem_local_responder dut (
    .clk (clk),
    .rst (rst),
    .mem (mem_if),
    .ram (ram_if)
  );

`ifdef MEM_LOCAL_INV_EN
  localparam logic        INV_EXP      = 1'b1;
  localparam logic [29:0] INV_ADDR_EXP = 30'h44;
`else
  localparam logic        INV_EXP      = 1'b0;
  localparam logic [29:0] INV_ADDR_EXP = 30'h0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM indexed by the low 12 address bits (all test addresses are distinct there).
  logic [31:0] ram_a [0:4095];

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (ram_if.en) begin
      if (ram_if.be == 4'b0000) ram_if.data_out <= ram_a[ram_if.addr[11:0]];
      else ram_a[ram_if.addr[11:0]] <= merge(ram_a[ram_if.addr[11:0]], ram_if.data_in, ram_if.be);
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rnw, input logic [29:0] a, input logic [4:0] rlen,
                       input logic [3:0] wbe, input logic [31:0] wdata, input logic [1:0] id);
    mem_if.request = 1'b1;
    mem_if.rnw     = rnw;
    mem_if.addr    = a;
    mem_if.rlen    = rlen;
    mem_if.wbe     = wbe;
    mem_if.wdata   = wdata;
    mem_if.id      = id;
  endtask

  logic [29:0] wrap_addr [0:3];
  logic [31:0] wrap_data [0:3];

  initial begin
    n_cmp = 0;
    n_mis = 0;
    for (int i = 0; i < 4096; i++) ram_a[i] = 32'h0;
    ram_a[12'h010] = 32'hDEADBEEF;
    for (int i = 0; i < 32; i++) ram_a[12'h100 + i] = 32'h100 + i;
    ram_a[12'h020] = 32'h11223344;
    ram_a[12'hFFE] = 32'hA0A0A0A0;
    ram_a[12'hFFF] = 32'hA1A1A1A1;
    ram_a[12'h000] = 32'hA2A2A2A2;
    ram_a[12'h001] = 32'hA3A3A3A3;
    wrap_addr[0] = 30'h3FFF_FFFE; wrap_data[0] = 32'hA0A0A0A0;
    wrap_addr[1] = 30'h3FFF_FFFF; wrap_data[1] = 32'hA1A1A1A1;
    wrap_addr[2] = 30'h0000_0000; wrap_data[2] = 32'hA2A2A2A2;
    wrap_addr[3] = 30'h0000_0001; wrap_data[3] = 32'hA3A3A3A3;
    ram_if.data_out = 32'h0;
    mem_if.rmw = 1'b0;

    // Reset with a request pending: nothing may be acked or accessed.
    rst = 1'b0;
    issue(1'b1, 30'h10, 5'd0, 4'h0, 32'h0, 2'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ack", mem_if.ack, 1'b0);
    check_eq("rst_rvalid", mem_if.rvalid, 1'b0);
    check_eq("rst_rid", mem_if.rid, 2'd0);
    check_eq("rst_en", ram_if.en, 1'b0);
    check_eq("rst_inv", mem_if.inv, 1'b0);
    check_eq("rst_inv_addr", mem_if.inv_addr, 30'h0);
    check_eq("wr_outstanding", mem_if.write_outstanding, 1'b0);
    nxt();
    rst = 1'b1;
    mem_if.request = 1'b0;
    @(negedge clk);
    check_eq("idle_ack", mem_if.ack, 1'b0);
    check_eq("idle_en", ram_if.en, 1'b0);

    // Single read
    nxt();
    issue(1'b1, 30'h10, 5'd0, 4'h0, 32'h0, 2'd2);
    @(negedge clk);
    check_eq("rd1_ack", mem_if.ack, 1'b1);
    check_eq("rd1_en", ram_if.en, 1'b1);
    check_eq("rd1_addr", ram_if.addr, 30'h10);
    check_eq("rd1_be", ram_if.be, 4'h0);
    nxt();
    mem_if.request = 1'b0;
    @(negedge clk);
    check_eq("rd1_rvalid", mem_if.rvalid, 1'b1);
    check_eq("rd1_rdata", mem_if.rdata, 32'hDEADBEEF);
    check_eq("rd1_rid", mem_if.rid, 2'd2);
    check_eq("rd1_en_after", ram_if.en, 1'b0);
    nxt();
    @(negedge clk);
    check_eq("rd1_rvalid_end", mem_if.rvalid, 1'b0);

    // 32-word burst, with a write waiting until T+32
    nxt();
    issue(1'b1, 30'h100, 5'd31, 4'h0, 32'h0, 2'd1);
    for (int k = 0; k <= 32; k++) begin
      @(negedge clk);
      check_eq("b32_ack", mem_if.ack, (k == 0) || (k == 32));
      if (k > 0) begin
        check_eq("b32_rvalid", mem_if.rvalid, 1'b1);
        check_eq("b32_rdata", mem_if.rdata, 32'h100 + k - 1);
        check_eq("b32_rid", mem_if.rid, 2'd1);
      end
      if (k < 32) begin
        check_eq("b32_en", ram_if.en, 1'b1);
        check_eq("b32_addr", ram_if.addr, 30'h100 + k);
      end
      nxt();
      if (k == 0) issue(1'b0, 30'h200, 5'd31, 4'hF, 32'h55, 2'd0);
    end
    mem_if.request = 1'b0;
    @(negedge clk);
    check_eq("b32_rvalid_end", mem_if.rvalid, 1'b0);
    check_eq("b32_wr_data", ram_a[12'h200], 32'h55);

    // Write with byte enables, then read back
    nxt();
    issue(1'b0, 30'h20, 5'd7, 4'b0101, 32'hAABBCCDD, 2'd0);
    @(negedge clk);
    check_eq("wbe_ack", mem_if.ack, 1'b1);
    check_eq("wbe_be", ram_if.be, 4'b0101);
    nxt();
    issue(1'b1, 30'h20, 5'd0, 4'h0, 32'h0, 2'd0);
    @(negedge clk);
    check_eq("wbe_rd_ack", mem_if.ack, 1'b1);
    nxt();
    mem_if.request = 1'b0;
    @(negedge clk);
    check_eq("wbe_rvalid", mem_if.rvalid, 1'b1);
    check_eq("wbe_rdata", mem_if.rdata, 32'h11BB33DD);

    // Address wrap with a back-to-back write acked alongside the last rvalid
    nxt();
    issue(1'b1, 30'h3FFF_FFFE, 5'd3, 4'h0, 32'h0, 2'd3);
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      check_eq("wrap_ack", mem_if.ack, (k == 0) || (k == 4));
      check_eq("wrap_en", ram_if.en, 1'b1);
      if (k < 4) check_eq("wrap_addr", ram_if.addr, wrap_addr[k]);
      else check_eq("wrap_wr_addr", ram_if.addr, 30'h30);
      if (k > 0) begin
        check_eq("wrap_rvalid", mem_if.rvalid, 1'b1);
        check_eq("wrap_rdata", mem_if.rdata, wrap_data[k-1]);
        check_eq("wrap_rid", mem_if.rid, 2'd3);
      end
      nxt();
      if (k == 0) issue(1'b0, 30'h30, 5'd0, 4'hF, 32'h12345678, 2'd0);
    end
    mem_if.request = 1'b0;
    @(negedge clk);
    check_eq("wrap_rvalid_end", mem_if.rvalid, 1'b0);
    check_eq("wrap_wr_data", ram_a[12'h030], 32'h12345678);

    // Reset asserted at T+3 of an 8-word burst
    nxt();
    issue(1'b1, 30'h100, 5'd7, 4'h0, 32'h0, 2'd2);
    @(negedge clk);
    check_eq("rmb_ack", mem_if.ack, 1'b1);
    nxt();
    mem_if.request = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      check_eq("rmb_rdata", mem_if.rdata, 32'h100 + k - 1);
      nxt();
    end
    rst = 1'b0;
    nxt();
    @(negedge clk);
    check_eq("rmb_en_t4", ram_if.en, 1'b0);
    check_eq("rmb_rvalid_t4", mem_if.rvalid, 1'b0);
    nxt();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check_eq("rmb_en_post", ram_if.en, 1'b0);
      check_eq("rmb_rvalid_post", mem_if.rvalid, 1'b0);
      nxt();
    end
    issue(1'b1, 30'h20, 5'd0, 4'h0, 32'h0, 2'd1);
    @(negedge clk);
    check_eq("rmb_new_ack", mem_if.ack, 1'b1);
    nxt();
    mem_if.request = 1'b0;
    @(negedge clk);
    check_eq("rmb_new_rvalid", mem_if.rvalid, 1'b1);
    check_eq("rmb_new_rdata", mem_if.rdata, 32'h11BB33DD);
    check_eq("rmb_new_rid", mem_if.rid, 2'd1);

    // Invalidate pulse after a write
    nxt();
    issue(1'b0, 30'h44, 5'd0, 4'hF, 32'hCAFEF00D, 2'd0);
    @(negedge clk);
    check_eq("inv_wr_ack", mem_if.ack, 1'b1);
    check_eq("inv_t0", mem_if.inv, 1'b0);
    nxt();
    mem_if.request = 1'b0;
    @(negedge clk);
    check_eq("inv_t1", mem_if.inv, INV_EXP);
    check_eq("inv_addr_t1", mem_if.inv_addr, INV_ADDR_EXP);
    nxt();
    @(negedge clk);
    check_eq("inv_t2", mem_if.inv, 1'b0);
    check_eq("inv_wr_data", ram_a[12'h044], 32'hCAFEF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
